// File: rtl/even_seq_gen_if.sv
// even_seq_gen_if: value stream from the even-number source to the capture stage.
//   out       : current even value (source -> sink)
//   out_valid : out holds a value to be consumed (source -> sink)
//   out_ready : sink can accept this cycle (sink -> source)
//   wrap      : first value after a wrap-around (source -> sink)
interface even_seq_gen_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             wrap;

  modport master (output out, output out_valid, output wrap, input out_ready);
  modport slave  (input out, input out_valid, input wrap, output out_ready);
endinterface

// File: rtl/even_seq_gen.sv
// even_seq_gen: emits 0,2,...,LIMIT (or descending) one value per accepted
// handshake, wrapping at the ends.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   en         : run request (0 = stop after the current value is consumed)
//   dir        : 0 = +2, 1 = -2, sampled on accept
//   load       : synchronous reload strobe, beats accept
//   load_val   : reload value, LSB forced to 0, clamped to LIMIT
//   sq         : output stream (out/out_valid/out_ready/wrap)
module even_seq_gen #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  even_seq_gen_if.master   sq
);

  if ((LIMIT % 2) != 0 || LIMIT < 0 || LIMIT >= (1 << WIDTH)) begin : g_bad_limit
    $error("even_seq_gen: LIMIT must be even and fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] LIM  = LIMIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] STEP = WIDTH'(2);
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, RUN, RELOAD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             wrap_q, wrap_d;
  logic             accept;
  logic [WIDTH-1:0] load_even;

  assign sq.out       = val_q;
  assign sq.out_valid = (state_q == RUN);
  assign sq.wrap      = wrap_q;

  assign accept    = sq.out_valid & sq.out_ready;
  assign load_even = {load_val[WIDTH-1:1], 1'b0};

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    // wrap is a pulse: it clears on every edge unless a wrapping accept sets it
    wrap_d  = 1'b0;
    if (load) begin
      // an accept in the same cycle is swallowed: value not advanced, no wrap
      state_d = RELOAD;
      val_d   = (load_even > LIM) ? LIM : load_even;
    end else begin
      unique case (state_q)
        IDLE:   if (en) state_d = RUN;
        RUN: begin
          if (accept) begin
            if (!dir) begin
              val_d  = (val_q == LIM) ? ZERO : val_q + STEP;
              wrap_d = (val_q == LIM);
            end else begin
              val_d  = (val_q == ZERO) ? LIM : val_q - STEP;
              wrap_d = (val_q == ZERO);
            end
            state_d = en ? RUN : IDLE;
          end
        end
        RELOAD: state_d = en ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule
